// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared constants, entry type and RVC classifier for the fetch queue
package fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int FQ_XLEN  = 32;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_XLEN-1:0] instr;
    logic               is_comp;
    logic               err;
  } fq_entry_t;

  // A parcel whose two low opcode bits are not 2'b11 starts a 16-bit RVC instruction.
  function automatic logic is_compressed(input logic [1:0] op);
    return (op != 2'b11);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - enqueue/dequeue handshake bundle between align buffer, queue and decode
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);

  // Enqueue side (align buffer -> queue)
  logic                       enq_valid_i;
  logic                       enq_ready_o;
  logic [XLEN-1:0]            enq_pc_i;
  logic [XLEN-1:0]            enq_instr_i;
  logic                       enq_err_i;
  logic                       almost_full_o;

  // Dequeue side (queue -> decode)
  logic                       deq_valid_o;
  logic                       deq_ready_i;
  logic [XLEN-1:0]            deq_pc_o;
  logic [XLEN-1:0]            deq_instr_o;
  logic                       deq_is_comp_o;
  logic                       deq_err_o;

  // Status
  logic [$clog2(DEPTH+1)-1:0] count_o;

  // Surrounding pipeline: drives words in and ready back
  modport master (
    output enq_valid_i, enq_pc_i, enq_instr_i, enq_err_i, deq_ready_i,
    input  enq_ready_o, almost_full_o, deq_valid_o, deq_pc_o, deq_instr_o,
           deq_is_comp_o, deq_err_o, count_o
  );

  // The queue itself
  modport slave (
    input  enq_valid_i, enq_pc_i, enq_instr_i, enq_err_i, deq_ready_i,
    output enq_ready_o, almost_full_o, deq_valid_o, deq_pc_o, deq_instr_o,
           deq_is_comp_o, deq_err_o, count_o
  );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - first-word-fall-through instruction FIFO between align buffer and decode
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int XLEN  = FQ_XLEN
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  fetch_queue_if.slave  fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; no reset needed, outputs are don't-care while empty
  logic [XLEN-1:0] r_pc      [DEPTH];
  logic [XLEN-1:0] r_instr   [DEPTH];
  logic            r_is_comp [DEPTH];
  logic            r_err     [DEPTH];

  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_deq_valid;
  logic            w_push;
  logic            w_pop;

  // Ready looks only at the registered count so no path runs from deq_ready to enq_ready;
  // a full queue refuses a push even if it pops in the same cycle.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_deq_valid = (r_count != '0) && !flush_i;
  assign w_push      = fq.enq_valid_i && !w_full && !flush_i;
  assign w_pop       = w_deq_valid && fq.deq_ready_i;

  assign fq.enq_ready_o   = !w_full;
  assign fq.almost_full_o = (r_count >= CW'(DEPTH-1));
  assign fq.deq_valid_o   = w_deq_valid;
  assign fq.deq_pc_o      = r_pc[r_head];
  assign fq.deq_instr_o   = r_instr[r_head];
  assign fq.deq_is_comp_o = r_is_comp[r_head];
  assign fq.deq_err_o     = r_err[r_head];
  assign fq.count_o       = r_count;

  // Write the incoming word at the tail; the RVC class is decided once here for decode
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc[r_tail]      <= fq.enq_pc_i;
      r_instr[r_tail]   <= fq.enq_instr_i;
      r_is_comp[r_tail] <= is_compressed(fq.enq_instr_i[1:0]);
      r_err[r_tail]     <= fq.enq_err_i;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Occupancy invariants: no overflow, no underflow, count consistent with the pointers
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(w_push && w_full));
      assert (!(w_pop && (r_count == '0)));
      if (w_full)
        assert (r_tail == r_head);
      else
        assert (CW'(PW'(r_tail - r_head)) == r_count);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

  logic clk_i;
  logic rst_ni;
  logic flush_i;

  int n_checks;
  int n_errors;

  fetch_queue_if #(.XLEN(32), .DEPTH(4)) fq_bus ();

  fetch_queue #(.DEPTH(4), .XLEN(32)) u_dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .fq      (fq_bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_enq(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic err);
    fq_bus.enq_valid_i = v;
    fq_bus.enq_pc_i    = pc;
    fq_bus.enq_instr_i = instr;
    fq_bus.enq_err_i   = err;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    fq_bus.deq_ready_i = 1'b0;
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    check("rst_deq_valid",  32'(fq_bus.deq_valid_o), 32'd0);
    check("rst_enq_ready",  32'(fq_bus.enq_ready_o), 32'd1);
    check("rst_almost_full", 32'(fq_bus.almost_full_o), 32'd0);
    check("rst_count",      32'(fq_bus.count_o), 32'd0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    check("idle_deq_valid", 32'(fq_bus.deq_valid_o), 32'd0);
    check("idle_count",     32'(fq_bus.count_o), 32'd0);

    // two words held, then drained in order
    drive_enq(1'b1, 32'h10, 32'h0000_0013, 1'b0);
    step();
    check("lat_deq_valid", 32'(fq_bus.deq_valid_o), 32'd1);
    drive_enq(1'b1, 32'h14, 32'h0000_4501, 1'b0);
    step();
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("two_count",   32'(fq_bus.count_o), 32'd2);
    check("two_pc0",     fq_bus.deq_pc_o, 32'h10);
    check("two_comp0",   32'(fq_bus.deq_is_comp_o), 32'd0);
    fq_bus.deq_ready_i = 1'b1;
    step();
    check("two_pc1",     fq_bus.deq_pc_o, 32'h14);
    check("two_comp1",   32'(fq_bus.deq_is_comp_o), 32'd1);
    check("two_instr1",  fq_bus.deq_instr_o, 32'h0000_4501);
    check("two_count1",  32'(fq_bus.count_o), 32'd1);
    step();
    check("two_empty",   32'(fq_bus.deq_valid_o), 32'd0);
    fq_bus.deq_ready_i = 1'b0;

    // fill to full with wrapped pointers, then hold a fifth word
    for (int i = 0; i < 4; i++) begin
      drive_enq(1'b1, 32'h100 + 32'(4*i), 32'h0000_0013, 1'b0);
      step();
      if (i == 2) begin
        check("fill_af",    32'(fq_bus.almost_full_o), 32'd1);
        check("fill_rdy3",  32'(fq_bus.enq_ready_o), 32'd1);
      end
    end
    check("full_ready", 32'(fq_bus.enq_ready_o), 32'd0);
    check("full_count", 32'(fq_bus.count_o), 32'd4);
    drive_enq(1'b1, 32'h110, 32'h0000_0013, 1'b0);
    step();
    check("held_count", 32'(fq_bus.count_o), 32'd4);
    check("held_head",  fq_bus.deq_pc_o, 32'h100);
    fq_bus.deq_ready_i = 1'b1;
    step();
    fq_bus.deq_ready_i = 1'b0;
    check("pop_count",  32'(fq_bus.count_o), 32'd3);
    check("pop_ready",  32'(fq_bus.enq_ready_o), 32'd1);
    step();
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("refill_count", 32'(fq_bus.count_o), 32'd4);
    fq_bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("wrap_valid", 32'(fq_bus.deq_valid_o), 32'd1);
      check("wrap_pc",    fq_bus.deq_pc_o, 32'h104 + 32'(4*i));
      step();
    end
    check("wrap_empty", 32'(fq_bus.count_o), 32'd0);
    fq_bus.deq_ready_i = 1'b0;

    // steady push and pop at occupancy two
    drive_enq(1'b1, 32'h300, 32'h0000_0013, 1'b0);
    step();
    drive_enq(1'b1, 32'h304, 32'h0000_0013, 1'b0);
    step();
    fq_bus.deq_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_enq(1'b1, 32'h308 + 32'(4*i), 32'h0000_0013, 1'b0);
      check("stream_count", 32'(fq_bus.count_o), 32'd2);
      check("stream_pc",    fq_bus.deq_pc_o, 32'h300 + 32'(4*i));
      step();
    end
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("stream_tail_count", 32'(fq_bus.count_o), 32'd2);
    check("stream_tail_pc",    fq_bus.deq_pc_o, 32'h320);
    step();
    step();
    check("stream_drained", 32'(fq_bus.count_o), 32'd0);
    fq_bus.deq_ready_i = 1'b0;

    // flush with a concurrent enqueue
    for (int i = 0; i < 3; i++) begin
      drive_enq(1'b1, 32'h400 + 32'(4*i), 32'h0000_0013, 1'b0);
      step();
    end
    check("preflush_count", 32'(fq_bus.count_o), 32'd3);
    flush_i = 1'b1;
    fq_bus.deq_ready_i = 1'b1;
    drive_enq(1'b1, 32'h200, 32'h0000_0013, 1'b0);
    #1;
    check("flush_deq_valid", 32'(fq_bus.deq_valid_o), 32'd0);
    step();
    flush_i = 1'b0;
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("flush_count", 32'(fq_bus.count_o), 32'd0);
    check("flush_valid", 32'(fq_bus.deq_valid_o), 32'd0);
    step();
    check("flush_dropped", 32'(fq_bus.deq_valid_o), 32'd0);
    fq_bus.deq_ready_i = 1'b0;

    // error entry travels like any other
    drive_enq(1'b1, 32'hF8, 32'h0000_0013, 1'b1);
    step();
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("err_valid", 32'(fq_bus.deq_valid_o), 32'd1);
    check("err_flag",  32'(fq_bus.deq_err_o), 32'd1);
    check("err_pc",    fq_bus.deq_pc_o, 32'hF8);
    fq_bus.deq_ready_i = 1'b1;
    step();
    fq_bus.deq_ready_i = 1'b0;
    check("err_drained", 32'(fq_bus.count_o), 32'd0);

    // asynchronous reset between edges with two entries queued
    drive_enq(1'b1, 32'h500, 32'h0000_0013, 1'b0);
    step();
    drive_enq(1'b1, 32'h504, 32'h0000_0013, 1'b0);
    step();
    drive_enq(1'b0, 32'h0, 32'h0, 1'b0);
    check("prerst_count", 32'(fq_bus.count_o), 32'd2);
    #1;
    rst_ni = 1'b0;
    #1;
    check("arst_count", 32'(fq_bus.count_o), 32'd0);
    check("arst_valid", 32'(fq_bus.deq_valid_o), 32'd0);
    check("arst_ready", 32'(fq_bus.enq_ready_o), 32'd1);
    step();
    rst_ni = 1'b1;
    step();
    check("post_rst_count", 32'(fq_bus.count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
